// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter feeding a downstream SIPO register.
// Words arrive over a valid/ready handshake. One word can wait in a hold register.
// Each word is sent MSB first on d_out. frame marks every frame bit, and done marks the last one.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to each frame.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] hold_data, hold_data_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             hold_valid, hold_valid_nxt;
  logic             accept;
  logic             frame_end;
  logic             load_sreg;
  logic             d_out_nxt, frame_nxt, busy_nxt, done_nxt;
`ifdef PISO_PARITY_EN
  logic             par, par_nxt;
`endif

  // load_ready depends only on the registered hold flag, never on load_valid
  assign load_ready = !hold_valid;
  assign accept     = load_valid && load_ready;

`ifdef PISO_PARITY_EN
  assign frame_end  = (state == PARITY);
`else
  assign frame_end  = (state == SHIFT) && (cnt == '0);
`endif

  // A new word bypasses the hold register when the shifter is free, or about to become free, this edge
  assign load_sreg  = accept && ((state == IDLE) || frame_end);

  // Next-state logic: shift, count down, chain frames from hold or the input, and buffer overflow words
  always_comb begin
    state_nxt      = state;
    sreg_nxt       = sreg;
    cnt_nxt        = cnt;
    hold_data_nxt  = hold_data;
    hold_valid_nxt = hold_valid;
`ifdef PISO_PARITY_EN
    par_nxt        = par;
`endif

    case (state)
      SHIFT: begin
        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end
`ifdef PISO_PARITY_EN
        else begin
          state_nxt = PARITY;
        end
`endif
      end
      default: ;
    endcase

    if (frame_end) begin
      if (hold_valid) begin
        sreg_nxt       = hold_data;
        hold_valid_nxt = 1'b0;
        cnt_nxt        = CNT_TOP;
        state_nxt      = SHIFT;
`ifdef PISO_PARITY_EN
        par_nxt        = ^hold_data;
`endif
      end else if (!accept) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    end

    if (load_sreg) begin
      sreg_nxt  = data_in;
      cnt_nxt   = CNT_TOP;
      state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
      par_nxt   = ^data_in;
`endif
    end else if (accept) begin
      hold_data_nxt  = data_in;
      hold_valid_nxt = 1'b1;
    end
  end

  // Output values for the next cycle come from the next state, so every output can be registered
  always_comb begin
    frame_nxt = (state_nxt != IDLE);
    busy_nxt  = (state_nxt != IDLE) || hold_valid_nxt;
    d_out_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (state_nxt == SHIFT) begin
      d_out_nxt = sreg_nxt[WIDTH-1];
`ifndef PISO_PARITY_EN
      done_nxt  = (cnt_nxt == '0);
`endif
    end
`ifdef PISO_PARITY_EN
    if (state_nxt == PARITY) begin
      d_out_nxt = par_nxt;
      done_nxt  = 1'b1;
    end
`endif
  end

  // Core state registers; reset drops any in-flight frame and any held word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      cnt        <= cnt_nxt;
      hold_data  <= hold_data_nxt;
      hold_valid <= hold_valid_nxt;
`ifdef PISO_PARITY_EN
      par        <= par_nxt;
`endif
    end
  end

  // Registered serial outputs, cleared asynchronously so the line goes idle at once on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= 1'b0;
      frame <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      d_out <= d_out_nxt;
      frame <= frame_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: self-checking bench for piso_tx (WIDTH=4), scoreboard plus vector table.
`timescale 1ns/1ps
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FLEN  = W + 1;
  localparam int BPN   = 8;
  localparam int C_ACC = 6;
`else
  localparam int FLEN  = W;
  localparam int BPN   = 7;
  localparam int C_ACC = 5;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, d_out, frame, busy, done;
  logic [W-1:0] down = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic b;
    logic last;
  } sb_t;
  sb_t sb[$];
  sb_t mon_r;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_serial;
    logic         exp_par;
    logic [W-1:0] exp_down;
  } vec_t;

  piso_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .d_out     (d_out),
    .frame     (frame),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Model of the downstream 4-stage SIPO register
  always @(posedge clk) down <= {down[W-2:0], d_out};

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] word, input logic valid);
    @(posedge clk);
    #1;
    data_in    = word;
    load_valid = valid;
  endtask

  task automatic pushFrame(input logic [W-1:0] word);
    for (int i = W - 1; i >= 0; i--) begin
      sb.push_back('{word[i], (i == 0) && (FLEN == W)});
    end
`ifdef PISO_PARITY_EN
    sb.push_back('{^word, 1'b1});
`endif
  endtask

  task automatic waitDrain(input string name);
    int i = 0;
    while ((sb.size() != 0 || busy) && i < 200) begin
      @(negedge clk);
      i++;
    end
    checkOutput(name, (i < 200), 1'b1);
  endtask

  // Scoreboard monitor: compare serial line against queued expectations, then record new accepts
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      checkOutput("mon_frame", frame, sb.size() != 0);
      if (sb.size() != 0) begin
        mon_r = sb.pop_front();
        checkOutput("mon_d_out", d_out, mon_r.b);
        checkOutput("mon_done", done, mon_r.last);
      end else begin
        checkOutput("mon_idle_d_out", d_out, 1'b0);
        checkOutput("mon_idle_done", done, 1'b0);
      end
      if (load_valid && load_ready) pushFrame(data_in);
    end
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    tests++;
    fails++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    vec_t         vecs[6];
    logic [2*FLEN-1:0] b2b_bits;
    logic [7:0]   bp_ready;
    logic [W-1:0] bp_words[3];
    int           acc_cyc[3];
    int           bp_idx;

    vecs[0] = '{4'b1011, 4'b1011, 1'b1, 4'b1011};
    vecs[1] = '{4'b0110, 4'b0110, 1'b0, 4'b0110};
    vecs[2] = '{4'b1000, 4'b1000, 1'b1, 4'b1000};
    vecs[3] = '{4'b0001, 4'b0001, 1'b1, 4'b0001};
    vecs[4] = '{4'b1111, 4'b1111, 1'b0, 4'b1111};
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
`ifdef PISO_PARITY_EN
    b2b_bits = 10'b1100000110;
    bp_ready = 8'b11000010;
`else
    b2b_bits = 8'b11000011;
    bp_ready = 8'b01100010;
`endif
    bp_words[0] = 4'b1010;
    bp_words[1] = 4'b0101;
    bp_words[2] = 4'b1110;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_d_out", d_out, 1'b0);
    checkOutput("rst_frame", frame, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_load_ready", load_ready, 1'b1);
    rst_n = 1'b1;

    // Table-driven single frames from IDLE
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].word, 1'b1);
      applyStimulus('0, 1'b0);
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        checkOutput($sformatf("vec%0d_d_out_b%0d", v, k), d_out, vecs[v].exp_serial[W-1-k]);
        checkOutput($sformatf("vec%0d_frame_b%0d", v, k), frame, 1'b1);
        checkOutput($sformatf("vec%0d_done_b%0d", v, k), done, (FLEN == W) && (k == W - 1));
      end
`ifdef PISO_PARITY_EN
      @(negedge clk);
      checkOutput($sformatf("vec%0d_parity", v), d_out, vecs[v].exp_par);
      checkOutput($sformatf("vec%0d_par_frame", v), frame, 1'b1);
      checkOutput($sformatf("vec%0d_par_done", v), done, 1'b1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_down", v), down, {vecs[v].exp_serial[W-2:0], vecs[v].exp_par});
`else
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_down", v), down, vecs[v].exp_down);
`endif
      @(negedge clk);
      checkOutput($sformatf("vec%0d_end_frame", v), frame, 1'b0);
      checkOutput($sformatf("vec%0d_end_done", v), done, 1'b0);
      checkOutput($sformatf("vec%0d_end_busy", v), busy, 1'b0);
    end

    // Back-to-back frames with no idle gap
    applyStimulus(4'b1100, 1'b1);
    fork
      begin
        applyStimulus(4'b0011, 1'b1);
        applyStimulus('0, 1'b0);
      end
      begin
        @(posedge clk);
        for (int k = 0; k < 2 * FLEN; k++) begin
          @(negedge clk);
          checkOutput($sformatf("b2b_d_out_%0d", k), d_out, b2b_bits[2*FLEN-1-k]);
          checkOutput($sformatf("b2b_frame_%0d", k), frame, 1'b1);
          checkOutput($sformatf("b2b_done_%0d", k), done, (k == FLEN - 1) || (k == 2 * FLEN - 1));
        end
      end
    join
    waitDrain("b2b_drain");

    // Backpressure: valid held high with A, B, C
    bp_idx = 0;
    for (int i = 0; i < 3; i++) acc_cyc[i] = -1;
    for (int c = 0; c < BPN; c++) begin
      @(posedge clk);
      #1;
      load_valid = (bp_idx < 3);
      data_in    = bp_words[(bp_idx < 3) ? bp_idx : 0];
      @(negedge clk);
      checkOutput($sformatf("bp_ready_c%0d", c), load_ready, bp_ready[BPN-1-c]);
      if (load_valid && load_ready) begin
        acc_cyc[bp_idx] = c;
        bp_idx++;
      end
    end
    checkOutput("bp_acc_A", acc_cyc[0], 0);
    checkOutput("bp_acc_B", acc_cyc[1], 1);
    checkOutput("bp_acc_C", acc_cyc[2], C_ACC);
    applyStimulus('0, 1'b0);
    waitDrain("bp_drain");

    // Reset mid-frame with a held word pending
    applyStimulus(4'b1111, 1'b1);
    applyStimulus(4'b0101, 1'b1);
    applyStimulus('0, 1'b0);
    checkOutput("mid_busy_before", busy, 1'b1);
    checkOutput("mid_ready_before", load_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_d_out", d_out, 1'b0);
    checkOutput("mid_rst_frame", frame, 1'b0);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_ready", load_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_frame_%0d", k), frame, 1'b0);
      checkOutput($sformatf("post_rst_done_%0d", k), done, 1'b0);
      checkOutput($sformatf("post_rst_busy_%0d", k), busy, 1'b0);
      checkOutput($sformatf("post_rst_d_out_%0d", k), d_out, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter that sits directly upstream of the 4-stage serial-in parallel-out shift register. It accepts parallel words over a valid/ready handshake, holds up to one pending word, and shifts each word out MSB first on a single serial line with a framing strobe. After WIDTH bit-cycles, the downstream shift register holds the word in its original bit order. An optional parity bit can be appended per frame.

## Interface
- WIDTH, 4: word width in bits; legal range 2..16. Matches the downstream register depth.
- clk  in  1  rising-edge clock shared with the downstream shift register
- rst_n  in  1  asynchronous active-low reset
- data_in  in  WIDTH  parallel word to transmit
- load_valid  in  1  data_in is valid this cycle
- load_ready  out  1  block can accept a word this cycle; equals !hold_valid
- d_out  out  1  serial data; drives the downstream d_in
- frame  out  1  high in every cycle where d_out carries a frame bit
- busy  out  1  shifter active or hold register occupied
- done  out  1  one-cycle pulse in the cycle that carries the last bit of a frame

## Operation
- Storage:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH+1)
  - hold register hold_data plus flag hold_valid
- Accept condition: load_valid && load_ready at a rising edge.
- FSM states:
  - IDLE: frame=0, d_out=0.
  - SHIFT: d_out=sreg[WIDTH-1], frame=1. cnt counts WIDTH-1 down to 0. On each edge, sreg shifts left and a 0 fills the LSB.
  - PARITY: only with the macro; see Configuration.
- Word routing:
  - An accepted word goes straight into sreg if the FSM is in IDLE, or if it is in the final frame cycle and hold_valid=0.
  - Otherwise the accepted word goes into the hold register.
- End of frame (final frame cycle):
  - If hold_valid=1, hold_data moves into sreg, hold_valid clears, and the FSM enters SHIFT with cnt=WIDTH-1.
  - Else, if a word is accepted this cycle, the same transition happens with the new word.
  - Else the FSM returns to IDLE.
- Simultaneous events:
  - Hold full, final frame cycle, load_valid=1: load_ready=0, so the word is not taken. It is accepted the next cycle, into hold.
  - load_valid held while load_ready=0: data_in must stay stable until accepted.
- done=1 in exactly one cycle per frame, coincident with the last bit. busy = (state!=IDLE) || hold_valid.
- Reset mid-operation:
  - The in-flight frame and any held word are discarded; no done pulse is generated.
  - Outputs go to reset values immediately (asynchronous).

## Timing
- Reset values: d_out=0, frame=0, done=0, busy=0, load_ready=1, state=IDLE, hold_valid=0, cnt=0.
- A word accepted at edge N from IDLE:
  - data_in[WIDTH-1] appears on d_out in cycle N+1, and data_in[i] in cycle N+WIDTH-i.
  - frame is high for cycles N+1..N+WIDTH.
  - done is high in cycle N+WIDTH.
- Downstream alignment: at the edge ending cycle N+WIDTH, the downstream register captures the last bit. Its output then equals the word, with bit WIDTH-1 at d_out[WIDTH-1].
- Streaming: back-to-back frames have zero idle cycles between them. Throughput is one word per WIDTH cycles (WIDTH+1 with parity).
- load_ready is combinational from registered state only; it has no combinational path from load_valid.
- All outputs except load_ready are registered.

## Configuration
- PISO_PARITY_EN defined:
  - After the LSB, the FSM enters PARITY for one cycle.
  - d_out = XOR of the frame's WIDTH data bits (even parity), frame=1.
  - done moves to the PARITY cycle. The end-of-frame rules apply at PARITY instead of at the LSB.
  - The frame is WIDTH+1 cycles. The downstream register then holds bits [WIDTH-2:0] plus parity; this mode is for links that check parity.
- PISO_PARITY_EN undefined: no PARITY state. The frame is exactly WIDTH cycles and done coincides with the LSB.

## Test plan
- Reset, then load 4'b1011 at edge N from IDLE:
  - d_out must be 1,0,1,1 in cycles N+1..N+4, with frame=1 in those cycles.
  - done=1 only in N+4.
  - Downstream d_out must be 4'b1011 after edge N+4.
- Back-to-back: load 4'b1100, then 4'b0011 while the first is shifting:
  - d_out must be 1,1,0,0,0,0,1,1 in consecutive cycles with no gap.
  - Two done pulses, at cycles 4 and 8.
- Backpressure: hold load_valid high with words A, B, C from cycle 0:
  - A and B accepted in cycles 0 and 1.
  - load_ready=0 from cycle 2 until hold drains at A's last bit (cycle 4).
  - C accepted in cycle 5; all three frames are transmitted in order.
- Reset mid-frame: assert rst_n=0 during bit 2 of 4'b1111 with a held word pending:
  - Outputs go to reset values immediately.
  - After release, the line stays idle with no done pulse and busy=0.
- With PISO_PARITY_EN: load 4'b1011:
  - d_out must be 1,0,1,1,1, with frame high for 5 cycles.
  - done occurs in the fifth cycle.
- With PISO_PARITY_EN: load 4'b0110 → parity bit must be 0.
